// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results with
// long-latency results queued in a small FIFO, forcing a FIFO pop when the
// queue has been starved by ALU traffic for STARVE_LIMIT cycles.
module wb_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid_i,
  input  logic [ADDR_W-1:0]             alu_rd_i,
  input  logic [DATA_W-1:0]             alu_data_i,
  output logic                          alu_stall_o,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic [ADDR_W-1:0]             mem_rd_i,
  input  logic [DATA_W-1:0]             mem_data_i,
  output logic                          reg_wr_o,
  output logic [ADDR_W-1:0]             wr_reg_o,
  output logic [DATA_W-1:0]             wr_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          proto_err_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StW-1:0]    starve_q, starve_d;
  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              proto_err_q, proto_err_d;

  logic fifo_ne;
  logic push;
  logic pop;
  logic alu_sel;
  logic alu_ok;

  // Status outputs come straight from registered state only.
  assign fifo_ne      = (count_q != '0);
  assign mem_ready_o  = (count_q < CntW'(FIFO_DEPTH));
  assign alu_stall_o  = (starve_q == StW'(STARVE_LIMIT));
  assign fifo_count_o = count_q;
  assign reg_wr_o     = reg_wr_q;
  assign wr_reg_o     = wr_reg_q;
  assign wr_data_o    = wr_data_q;
  assign proto_err_o  = proto_err_q;

  // Write-port selection, FIFO pointer/count and starvation bookkeeping.
  always_comb begin
    alu_ok  = alu_valid_i && (alu_rd_i != '0);
    // x0 results complete the handshake but are never stored.
    push    = mem_valid_i && mem_ready_o && (mem_rd_i != '0);
    pop     = 1'b0;
    alu_sel = 1'b0;

    if (alu_stall_o && fifo_ne) begin
      pop = 1'b1;
    end else if (alu_ok) begin
      alu_sel = 1'b1;
    end else if (fifo_ne) begin
      pop = 1'b1;
    end

    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    starve_d = starve_q;
    if (pop || !fifo_ne) begin
      starve_d = '0;
    end else if (starve_q != StW'(STARVE_LIMIT)) begin
      starve_d = starve_q + StW'(1);
    end

    reg_wr_d  = pop || alu_sel;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_reg_d  = rd_mem_q[rptr_q];
      wr_data_d = data_mem_q[rptr_q];
    end else if (alu_sel) begin
      wr_reg_d  = alu_rd_i;
      wr_data_d = alu_data_i;
    end

    proto_err_d = proto_err_q || (alu_valid_i && alu_stall_o);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      reg_wr_q    <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      reg_wr_q    <= reg_wr_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= mem_rd_i;
      data_mem_q[wptr_q] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: queue-based reference model,
// per-cycle comparison of all outputs, plus directed literal checks.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 7;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        reg_wr;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [2:0]  fifo_count;
  logic        proto_err;

  wb_write_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid_i  (alu_valid),
    .alu_rd_i     (alu_rd),
    .alu_data_i   (alu_data),
    .alu_stall_o  (alu_stall),
    .mem_valid_i  (mem_valid),
    .mem_ready_o  (mem_ready),
    .mem_rd_i     (mem_rd),
    .mem_data_i   (mem_data),
    .reg_wr_o     (reg_wr),
    .wr_reg_o     (wr_reg),
    .wr_data_o    (wr_data),
    .fifo_count_o (fifo_count),
    .proto_err_o  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, starvation as a plain cycle count.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  bit          m_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          m_err;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_wr     = 0;
    m_reg    = '0;
    m_data   = '0;
    m_err    = 0;
  endtask

  task automatic model_step(output bit acc);
    bit   ne;
    bit   stall;
    bit   alu_write;
    bit   popped;
    ent_t e;
    ne        = (mq.size() > 0);
    stall     = (m_starve == LIMIT);
    alu_write = alu_valid && (alu_rd != 0);
    popped    = 0;
    acc       = mem_valid && (mq.size() < DEPTH);
    if (alu_valid && stall) m_err = 1;
    if (ne && (stall || !alu_write)) begin
      e      = mq.pop_front();
      m_wr   = 1;
      m_reg  = e.rd;
      m_data = e.data;
      popped = 1;
    end else if (alu_write) begin
      m_wr   = 1;
      m_reg  = alu_rd;
      m_data = alu_data;
    end else begin
      m_wr = 0;
    end
    if (acc && mem_rd != 0) mq.push_back({mem_rd, mem_data});
    if (popped || !ne) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      output bit acc);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    @(posedge clk);
    model_step(acc);
    @(negedge clk);
  endtask

  task automatic idle();
    bit a;
    step(0, 0, 0, 0, 0, 0, a);
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("reg_wr", reg_wr, m_wr);
      chk("wr_reg", wr_reg, m_reg);
      chk("wr_data", wr_data, m_data);
      chk("fifo_count", fifo_count, mq.size());
      chk("mem_ready", mem_ready, mq.size() < DEPTH);
      chk("alu_stall", alu_stall, m_starve == LIMIT);
      chk("proto_err", proto_err, m_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    int          n;
    int          got;
    logic [4:0]  log_rd [10];
    logic [31:0] log_dt [10];

    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", mem_ready, 1);
    chk("rst_stall", alu_stall, 0);
    chk("rst_err", proto_err, 0);
    rst = 0;
    chk_on = 1;

    // ALU path, then x0 write suppressed.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, acc);
    chk("alu_wr", reg_wr, 1);
    chk("alu_reg", wr_reg, 5);
    chk("alu_data", wr_data, 32'hDEADBEEF);
    idle();
    chk("alu_after", reg_wr, 0);
    step(1, 0, 32'h12345678, 0, 0, 0, acc);
    chk("alu_x0", reg_wr, 0);
    chk("alu_x0_hold", wr_data, 32'hDEADBEEF);

    // Contention: ALU first, queued result the cycle after.
    step(1, 3, 32'h11, 1, 4, 32'h22, acc);
    chk("cont_acc", acc, 1);
    chk("cont_n1_reg", wr_reg, 3);
    chk("cont_n1_data", wr_data, 32'h11);
    idle();
    chk("cont_n2_wr", reg_wr, 1);
    chk("cont_n2_reg", wr_reg, 4);
    chk("cont_n2_data", wr_data, 32'h22);
    idle();
    chk("cont_n3_wr", reg_wr, 0);

    // Ordering and pointer wrap with ALU idle.
    got = 0;
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, 1, 5'(i), 32'(i * 256), acc);
      chk("ord_acc", acc, 1);
      if (reg_wr && got < 10) begin
        log_rd[got] = wr_reg; log_dt[got] = wr_data; got++;
      end
    end
    n = 0;
    while (got < 10 && n < 20) begin
      idle();
      if (reg_wr) begin
        log_rd[got] = wr_reg; log_dt[got] = wr_data; got++;
      end
      n++;
    end
    chk("ord_count", got, 10);
    for (int i = 0; i < got; i++) begin
      chk("ord_entry", {log_rd[i], log_dt[i]}, {5'(i + 1), 32'((i + 1) * 256)});
    end
    chk("ord_empty", fifo_count, 0);

    // Full / backpressure under continuous ALU traffic.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'(i), 1, 5'(11 + i), 32'hA0 + 32'(i), acc);
      chk("full_acc", acc, 1);
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", mem_ready, 0);
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      step(m_starve != LIMIT, 1, 32'h5, 1, 15, 32'hA4, acc);
      n++;
    end
    chk("full_fifth_acc", acc, 1);
    n = 0;
    while (mq.size() > 0 && n < 20) begin idle(); n++; end
    chk("full_drain", fifo_count, 0);

    // Starvation: stall 7 cycles after the entry lands, then drop ALU.
    step(1, 2, 32'h1, 1, 9, 32'h99, acc);
    n = 0;
    while (!alu_stall && n < 20) begin
      step(1, 2, 32'h1, 0, 0, 0, acc);
      n++;
    end
    chk("starve_cycles", n, 7);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("starve_wr", reg_wr, 1);
    chk("starve_reg", wr_reg, 9);
    chk("starve_data", wr_data, 32'h99);
    chk("starve_clear", alu_stall, 0);
    chk("starve_noerr", proto_err, 0);

    // Protocol error: ALU driven during the stall is dropped.
    step(1, 2, 32'h1, 1, 10, 32'hAA, acc);
    n = 0;
    while (!alu_stall && n < 20) begin
      step(1, 2, 32'h1, 0, 0, 0, acc);
      n++;
    end
    step(1, 6, 32'h66, 0, 0, 0, acc);
    chk("perr_set", proto_err, 1);
    chk("perr_reg", wr_reg, 10);
    chk("perr_data", wr_data, 32'hAA);
    idle();
    chk("perr_lost", reg_wr, 0);
    chk("perr_sticky", proto_err, 1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          av;
      logic [4:0]  ard;
      logic [4:0]  mrd;
      av  = ($urandom_range(0, 3) != 0) && (m_starve != LIMIT || $urandom_range(0, 7) == 0);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(av, ard, $urandom, $urandom_range(0, 1) == 1, mrd, $urandom, acc);
    end

    // Reset mid-stream with three queued entries.
    n = 0;
    while (mq.size() > 0 && n < 20) begin idle(); n++; end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'h7, 1, 5'(20 + i), 32'hC0 + 32'(i), acc);
    end
    chk("mid_pre_count", fifo_count, 3);
    #1;
    rst = 1;
    model_reset();
    #1;
    chk("mid_reg_wr", reg_wr, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_ready", mem_ready, 1);
    chk("mid_err", proto_err, 0);
    alu_valid = 0; mem_valid = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("mid_no_write", reg_wr, 0);
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the 32x32 register file. It owns the file's single write port: reg_wr, wr_reg and wr_data.
- Merges two result sources:
  - ALU results: single-cycle, no backpressure.
  - Long-latency results (load, multi-cycle units): valid/ready handshake, buffered in a small FIFO.
- Guarantees that queued long-latency results cannot be starved forever by a continuous ALU stream.

Parameters:
- DATA_W, 32, result and register data width.
- ADDR_W, 5, register index width.
- FIFO_DEPTH, 4, long-latency result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 7, consecutive cycles a non-empty FIFO may go unserved before alu_stall asserts.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- alu_stall  output  1  upstream must hold alu_valid=0 this cycle.
- mem_valid  input  1  long-latency result offered.
- mem_ready  output  1  FIFO can accept; transfer occurs when mem_valid&&mem_ready.
- mem_rd  input  ADDR_W  long-latency destination register.
- mem_data  input  DATA_W  long-latency result.
- reg_wr  output  1  register file write enable (registered).
- wr_reg  output  ADDR_W  register file write index (registered).
- wr_data  output  DATA_W  register file write data (registered).
- fifo_count  output  clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- proto_err  output  1  sticky: alu_valid seen while alu_stall=1.

Behaviour:
- Reset (async, immediate):
  - Outputs: reg_wr=0, wr_reg=0, wr_data=0, alu_stall=0, proto_err=0.
  - FIFO emptied: fifo_count=0, read/write pointers 0. mem_ready=1.
  - Starve counter=0.
  - Reset mid-operation discards all queued results and any pending write; no write is issued on the cycle reset deasserts.
- mem_ready = (fifo_count < FIFO_DEPTH), derived from registered count only.
  - A pop in the same cycle does NOT raise mem_ready while full.
- Enqueue on mem_valid&&mem_ready:
  - mem_rd==0: the transfer completes but nothing is stored (x0 writes discarded).
  - Otherwise {mem_rd, mem_data} is written at the tail.
- Write-port selection, evaluated each cycle (registered into reg_wr/wr_reg/wr_data on the next posedge, latency = 1 cycle):
  1. alu_stall==1 and FIFO non-empty: pop head, write it.
  2. Else alu_valid && alu_rd!=0: write ALU result.
  3. Else FIFO non-empty: pop head, write it. This includes cycles where alu_valid with alu_rd==0.
  4. Else reg_wr=0; wr_reg/wr_data hold their previous values.
- ALU x0 writes never assert reg_wr.
- FIFO ordering is strict first-in first-out. Simultaneous enqueue and pop when non-empty: count unchanged, both pointers advance.
- Enqueue into an empty FIFO cannot pop in the same cycle; earliest pop is the next cycle, so the earliest reg_wr is 2 cycles after the handshake.
- Pointers wrap modulo FIFO_DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- alu_stall = (starve counter == STARVE_LIMIT), decoded from the register. The forced pop clears the counter, so alu_stall lasts exactly 1 cycle per starvation event.
- If alu_valid=1 while alu_stall=1:
  - The FIFO still wins and the ALU result is dropped.
  - proto_err sets and holds until reset.
- Source ordering (WAW): upstream guarantees that ALU and queued long-latency results never target the same register out of program order. The arbiter performs no hazard checks.

Test Plan:
- Reset: assert rst mid-stream with 3 FIFO entries -> reg_wr=0, fifo_count=0, mem_ready=1 immediately; no writes after release until new stimulus.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle reg_wr=1, wr_reg=5, wr_data=0xDEADBEEF; following cycle reg_wr=0. Repeat with alu_rd=0 -> reg_wr stays 0.
- Contention: cycle N alu (rd=3, 0x11) and mem handshake (rd=4, 0x22) -> N+1 writes r3=0x11; N+2 writes r4=0x22 with no further ALU traffic.
- Full/backpressure: hold alu_valid=1 (rd=1) continuously; offer 5 mem results -> after 4 accepted, fifo_count=4 and mem_ready=0; 5th held until a pop frees a slot.
- Starvation: continuous ALU traffic with 1 FIFO entry -> alu_stall=1 exactly 1 cycle, 7 cycles after the entry lands. Bench drops alu_valid that cycle -> FIFO entry written next cycle, counter cleared. Re-run with alu_valid=1 during the stall -> proto_err=1 and the ALU result is lost.
- Ordering/wrap: enqueue 10 mem results (rd=1..10, data=rd*0x100) with alu idle -> writes emitted in order 1..10, pointers wrap twice, fifo_count returns to 0.
